// File: rtl/sclk_monitor_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the sclk_monitor block.
// Latency: n/a (types, constants and a state-decode helper only).
// Backpressure: n/a.
// Optional feature macro used by the top: SCLK_MON_AVG4_EN (average over AVG_N periods).
package sclk_mon_pkg;

  // Default width of the measurement counters and result outputs.
  localparam int CNT_W_DEFAULT = 16;

  // Number of periods averaged when the averaging build is selected.
  localparam int AVG_N  = 4;
  localparam int AVG_SH = $clog2(AVG_N);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    HIGH = 3'd2,
    LOW  = 3'd3,
    DONE = 3'd4
  } mon_state_e;

  // True while a measurement is in flight (drives busy and the gap counter).
  function automatic logic is_measuring(input mon_state_e s);
    return (s == ARM) || (s == HIGH) || (s == LOW);
  endfunction

endpackage

// File: rtl/sclk_monitor_if.sv
`timescale 1ns/1ps
// Request/result bundle between a requester and sclk_monitor.
// Latency: n/a (wires only).
// Backpressure: none; start is a one-cycle request, done a one-cycle result pulse.
// Ports: start (req), busy, done, timeout, period_cnt, high_cnt (results).
interface sclk_monitor_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;

  // Requester side.
  modport master (
    output start,
    input  busy, done, timeout, period_cnt, high_cnt
  );

  // Monitor side.
  modport slave (
    input  start,
    output busy, done, timeout, period_cnt, high_cnt
  );
endinterface

// File: rtl/sclk_monitor_edge_sync.sv
`timescale 1ns/1ps
// Synchronises an asynchronous level and emits single-cycle rise/fall pulses.
// Latency: SYNC_STAGES+1 clk cycles from input change to rise/fall pulse (same for both edges).
// Backpressure: none; free-running.
// Ports: clk, rst (sync, active-high), async_in -> rise, fall (pulses), level (synchronised level).
module sclk_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  assign level = sync_q[SYNC_STAGES-1];

  // Pulses are registered so both edges see exactly the same pipeline depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~hist_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

endmodule

// File: rtl/sclk_monitor.sv
`timescale 1ns/1ps
// Measures one period and high time of sclk_in in clk cycles, or flags a stuck input.
// Latency: done one cycle after the closing detected rise (or after TIMEOUT_CYC quiet cycles).
// Backpressure: none; start is only accepted in IDLE, otherwise dropped.
// Ports: clk, rst (sync, active-high), sclk_in (async), mon (slave: start/busy/done/timeout/period_cnt/high_cnt).
// Build option: define SCLK_MON_AVG4_EN to report the truncated mean over AVG_N consecutive periods.
module sclk_monitor
  import sclk_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int TIMEOUT_CYC = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk_in,
  sclk_monitor_if.slave mon
);

  // Gap counter value in the cycle before it would reach TIMEOUT_CYC, so
  // done lands exactly TIMEOUT_CYC cycles after the last clear.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mon_state_e state_q, state_d;

  logic             rise, fall, sync_level;
  logic [CNT_W-1:0] per_ctr, hi_ctr, gap_ctr;
  logic [CNT_W-1:0] period_q, high_q;
  logic             to_q;
  logic             gap_hit;
  logic             ld_res, ld_to;
  logic [CNT_W-1:0] res_per, res_hi;

  // Level is not needed here; only the edge pulses drive the measurement.
  logic unused_level;
  assign unused_level = sync_level;

  sclk_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sclk_in),
    .rise     (rise),
    .fall     (fall),
    .level    (sync_level)
  );

  assign gap_hit = (gap_ctr == GAP_LAST);

`ifdef SCLK_MON_AVG4_EN
  logic [CNT_W+1:0] sum_per, sum_hi;
  logic [CNT_W+1:0] sum_per_fin, sum_hi_fin;
  logic [1:0]       per_idx;

  // The last period's counts are folded in combinationally at the closing rise.
  assign sum_per_fin = sum_per + {2'b00, per_ctr};
  assign sum_hi_fin  = sum_hi  + {2'b00, hi_ctr};
  assign res_per     = CNT_W'(sum_per_fin >> AVG_SH);
  assign res_hi      = CNT_W'(sum_hi_fin  >> AVG_SH);
`else
  assign res_per = per_ctr;
  assign res_hi  = hi_ctr;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Edges are tested before gap_hit so a coincident edge wins over timeout.
  always_comb begin
    state_d = state_q;
    ld_res  = 1'b0;
    ld_to   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mon.start) state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          state_d = HIGH;
        end else if (gap_hit) begin
          state_d = DONE;
          ld_to   = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
        end else if (gap_hit) begin
          state_d = DONE;
          ld_to   = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
`ifdef SCLK_MON_AVG4_EN
          if (per_idx == 2'(AVG_N - 1)) begin
            state_d = DONE;
            ld_res  = 1'b1;
          end else begin
            state_d = HIGH;
          end
`else
          state_d = DONE;
          ld_res  = 1'b1;
`endif
        end else if (gap_hit) begin
          state_d = DONE;
          ld_to   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- Datapath
  // Counters start at 1 on the opening rise so that the value seen in the
  // cycle of a later edge equals the number of cycles since that rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_ctr  <= '0;
      hi_ctr   <= '0;
      gap_ctr  <= '0;
      period_q <= '0;
      high_q   <= '0;
      to_q     <= 1'b0;
`ifdef SCLK_MON_AVG4_EN
      sum_per  <= '0;
      sum_hi   <= '0;
      per_idx  <= '0;
`endif
    end else begin
      if ((state_q == IDLE && mon.start) || rise || fall) begin
        gap_ctr <= '0;
      end else if (is_measuring(state_q)) begin
        gap_ctr <= gap_ctr + CNT_W'(1);
      end

      case (state_q)
        ARM: begin
          if (rise) begin
            per_ctr <= CNT_W'(1);
            hi_ctr  <= CNT_W'(1);
`ifdef SCLK_MON_AVG4_EN
            sum_per <= '0;
            sum_hi  <= '0;
            per_idx <= '0;
`endif
          end
        end
        HIGH: begin
          per_ctr <= per_ctr + CNT_W'(1);
          // hi_ctr holds on the fall cycle: its value there is the high time.
          if (!fall) hi_ctr <= hi_ctr + CNT_W'(1);
        end
        LOW: begin
          if (rise) begin
`ifdef SCLK_MON_AVG4_EN
            // Closing rise of one period is the opening rise of the next.
            sum_per <= sum_per_fin;
            sum_hi  <= sum_hi_fin;
            per_idx <= per_idx + 2'd1;
            per_ctr <= CNT_W'(1);
            hi_ctr  <= CNT_W'(1);
`endif
          end else begin
            per_ctr <= per_ctr + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase

      if (ld_res) begin
        period_q <= res_per;
        high_q   <= res_hi;
        to_q     <= 1'b0;
      end else if (ld_to) begin
        period_q <= '0;
        high_q   <= '0;
        to_q     <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ Outputs
  // to_q is only visible during DONE so timeout stays a pulse.
  assign mon.busy       = is_measuring(state_q);
  assign mon.done       = (state_q == DONE);
  assign mon.timeout    = (state_q == DONE) & to_q;
  assign mon.period_cnt = period_q;
  assign mon.high_cnt   = high_q;

endmodule
